// File: rtl/video_timing_pkg.sv
// video_timing_pkg
// Shared types for the programmable video timing generator: the timing
// configuration record, its power-on value and the legality check applied
// when a new configuration is offered.
package video_timing_pkg;

    // Width of every counter and config field. The config struct is built at
    // this width, so a top-level CNT_W must match it.
    localparam int VT_CNT_W = 13;
    localparam int VT_SUM_W = VT_CNT_W + 1;

    typedef logic [VT_CNT_W-1:0] cnt_t;
    typedef logic [VT_SUM_W-1:0] sum_t;

    typedef struct packed {
        cnt_t h_total;
        cnt_t h_active;
        cnt_t h_fp;
        cnt_t h_sync;
        cnt_t v_total;
        cnt_t v_active;
        cnt_t v_fp;
        cnt_t v_sync;
        logic hs_neg;
        logic vs_neg;
    } timing_cfg_t;

    // 1920x1080 progressive, 2200x1125 total.
    localparam timing_cfg_t DEF_CFG = '{
        h_total:  cnt_t'(2200),
        h_active: cnt_t'(1920),
        h_fp:     cnt_t'(88),
        h_sync:   cnt_t'(44),
        v_total:  cnt_t'(1125),
        v_active: cnt_t'(1080),
        v_fp:     cnt_t'(4),
        v_sync:   cnt_t'(5),
        hs_neg:   1'b0,
        vs_neg:   1'b0
    };

    function automatic sum_t ext(input cnt_t v);
        return {1'b0, v};
    endfunction

    // Sums use one extra bit so a large fp+sync cannot wrap and sneak past.
    function automatic logic cfg_valid(input timing_cfg_t c);
        sum_t h_blank;
        sum_t v_blank;
        h_blank = ext(c.h_total) - ext(c.h_active);
        v_blank = ext(c.v_total) - ext(c.v_active);
        return (c.h_total >= cnt_t'(2))
            && (c.v_total != '0)
            && (c.h_active != '0) && (c.h_active < c.h_total)
            && (c.v_active != '0) && (c.v_active <= c.v_total)
            && ((ext(c.h_fp) + ext(c.h_sync)) <= h_blank)
            && ((ext(c.v_fp) + ext(c.v_sync)) <= v_blank);
    endfunction

endpackage

// File: rtl/video_timing_cfg_shadow.sv
// video_timing_cfg_shadow
// Holds a staged (validated) timing config and the active config used by the
// counters. Staged values move to active only at a frame boundary or while
// the generator is idle, so a mode change never lands mid-frame.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   load_i, cfg_i       load strobe and the config offered with it
//   frame_boundary_i    counters wrapping (h_total-1, v_total-1) -> (0,0)
//   idle_i              generator disabled; staged config may apply at once
//   active_cfg_o        config driving the counters/decode
//   pending_o           a validated config waits to be applied
//   err_o               one-cycle pulse for a rejected load
module video_timing_cfg_shadow
    import video_timing_pkg::*;
#(
    parameter timing_cfg_t RST_CFG = DEF_CFG
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  timing_cfg_t cfg_i,
    input  logic        frame_boundary_i,
    input  logic        idle_i,
    output timing_cfg_t active_cfg_o,
    output logic        pending_o,
    output logic        err_o
);

    timing_cfg_t staged_q, staged_d;
    timing_cfg_t active_q, active_d;
    logic        pending_q, pending_d;
    logic        err_q, err_d;
    logic        load_ok;
    logic        apply;

    assign load_ok = load_i && cfg_valid(cfg_i);
    assign apply   = pending_q && (frame_boundary_i || idle_i);

    always_comb begin
        staged_d  = staged_q;
        active_d  = active_q;
        pending_d = pending_q;
        err_d     = load_i && !load_ok;
        // Apply uses the old staged value; a load in the same cycle then
        // re-arms pending with the newer config.
        if (apply) begin
            active_d  = staged_q;
            pending_d = 1'b0;
        end
        if (load_ok) begin
            staged_d  = cfg_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            staged_q  <= RST_CFG;
            active_q  <= RST_CFG;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            staged_q  <= staged_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign active_cfg_o = active_q;
    assign pending_o    = pending_q;
    assign err_o        = err_q;

endmodule

// File: rtl/video_timing_gen_prog.sv
// video_timing_gen_prog
// Programmable progressive video timing generator. Horizontal/vertical
// counters run over the active config; decode is registered so every output
// lags the counter state by one cycle and all outputs stay mutually aligned.
// Ports:
//   pclk, rst                pixel clock, synchronous active-high reset
//   enable, pause            run control (low enable clears, pause freezes)
//   cfg_*, cfg_load          staged timing and its capture strobe
//   cfg_pending, cfg_err     staging status
//   hsync, vsync, de, x, y   timing outputs and active coordinates
//   line_start, frame_start  markers for hcnt = 0 / (hcnt, vcnt) = (0, 0)
module video_timing_gen_prog
    import video_timing_pkg::*;
#(
    parameter int CNT_W       = VT_CNT_W,
    parameter int DEF_H_TOTAL  = 2200,
    parameter int DEF_H_ACTIVE = 1920,
    parameter int DEF_H_FP     = 88,
    parameter int DEF_H_SYNC   = 44,
    parameter int DEF_V_TOTAL  = 1125,
    parameter int DEF_V_ACTIVE = 1080,
    parameter int DEF_V_FP     = 4,
    parameter int DEF_V_SYNC   = 5,
    parameter bit DEF_HS_NEG   = 1'b0,
    parameter bit DEF_VS_NEG   = 1'b0
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pause,
    input  logic [CNT_W-1:0] cfg_h_total,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_v_total,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic             cfg_hs_neg,
    input  logic             cfg_vs_neg,
    input  logic             cfg_load,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam timing_cfg_t RST_CFG = '{
        h_total:  cnt_t'(DEF_H_TOTAL),
        h_active: cnt_t'(DEF_H_ACTIVE),
        h_fp:     cnt_t'(DEF_H_FP),
        h_sync:   cnt_t'(DEF_H_SYNC),
        v_total:  cnt_t'(DEF_V_TOTAL),
        v_active: cnt_t'(DEF_V_ACTIVE),
        v_fp:     cnt_t'(DEF_V_FP),
        v_sync:   cnt_t'(DEF_V_SYNC),
        hs_neg:   DEF_HS_NEG,
        vs_neg:   DEF_VS_NEG
    };

    timing_cfg_t cfg_in;
    timing_cfg_t ac;

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;

    logic [CNT_W:0]   h_blank, v_blank, hs_end, vs_end;
    logic             hs_act, vs_act, pix_act, line_act;
    logic             h_last, v_last, frame_boundary;

    always_comb begin
        cfg_in          = '0;
        cfg_in.h_total  = cfg_h_total;
        cfg_in.h_active = cfg_h_active;
        cfg_in.h_fp     = cfg_h_fp;
        cfg_in.h_sync   = cfg_h_sync;
        cfg_in.v_total  = cfg_v_total;
        cfg_in.v_active = cfg_v_active;
        cfg_in.v_fp     = cfg_v_fp;
        cfg_in.v_sync   = cfg_v_sync;
        cfg_in.hs_neg   = cfg_hs_neg;
        cfg_in.vs_neg   = cfg_vs_neg;
    end

    video_timing_cfg_shadow #(
        .RST_CFG (RST_CFG)
    ) u_shadow (
        .clk_i            (pclk),
        .rst_i            (rst),
        .load_i           (cfg_load),
        .cfg_i            (cfg_in),
        .frame_boundary_i (frame_boundary),
        .idle_i           (!enable),
        .active_cfg_o     (ac),
        .pending_o        (cfg_pending),
        .err_o            (cfg_err)
    );

    // Decode of the current counter position against the active config.
    assign h_blank  = {1'b0, ac.h_total} - {1'b0, ac.h_active};
    assign v_blank  = {1'b0, ac.v_total} - {1'b0, ac.v_active};
    assign hs_end   = {1'b0, ac.h_fp} + {1'b0, ac.h_sync};
    assign vs_end   = {1'b0, ac.v_fp} + {1'b0, ac.v_sync};
    assign hs_act   = (hcnt_q >= ac.h_fp) && ({1'b0, hcnt_q} < hs_end);
    assign vs_act   = (vcnt_q >= ac.v_fp) && ({1'b0, vcnt_q} < vs_end);
    assign pix_act  = {1'b0, hcnt_q} >= h_blank;
    assign line_act = {1'b0, vcnt_q} >= v_blank;
    assign h_last   = hcnt_q == (ac.h_total - 1'b1);
    assign v_last   = vcnt_q == (ac.v_total - 1'b1);

    assign frame_boundary = enable && !pause && h_last && v_last;

    always_comb begin
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        x_d     = x_q;
        y_d     = y_q;
        de_d    = 1'b0;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (!enable) begin
            hcnt_d  = '0;
            vcnt_d  = '0;
            hsync_d = ac.hs_neg;
            vsync_d = ac.vs_neg;
            x_d     = '0;
            y_d     = '0;
        end else if (!pause) begin
            hsync_d = hs_act ^ ac.hs_neg;
            vsync_d = vs_act ^ ac.vs_neg;
            de_d    = pix_act && line_act;
            // Both differences are below h_total/v_total, so CNT_W bits hold them.
            x_d     = (pix_act && line_act) ? (hcnt_q - h_blank[CNT_W-1:0]) : '0;
            y_d     = line_act ? (vcnt_q - v_blank[CNT_W-1:0]) : '0;
            ls_d    = hcnt_q == '0;
            fs_d    = (hcnt_q == '0) && (vcnt_q == '0);
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hsync_q <= DEF_HS_NEG;
            vsync_q <= DEF_VS_NEG;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: doc/video_timing_gen_prog.md
# video_timing_gen_prog

Programmable progressive video timing generator with run-time timing registers, producing hsync/vsync/de plus pixel coordinates and frame/line markers. It is the parametrised successor to the fixed-mode sync generator: any mode that fits CNT_W-bit counters can be loaded. Timing is loaded through a validated shadow register, so a mode change never takes effect mid-frame. It sits at the head of the video output pipeline and feeds pattern generators, frame readers and the TX PHY.

## Interface
Parameters:
- CNT_W, 13, width of all horizontal and vertical counters and config fields.
- DEF_H_TOTAL / DEF_H_ACTIVE / DEF_H_FP / DEF_H_SYNC, 2200 / 1920 / 88 / 44, reset horizontal config.
- DEF_V_TOTAL / DEF_V_ACTIVE / DEF_V_FP / DEF_V_SYNC, 1125 / 1080 / 4 / 5, reset vertical config.
- DEF_HS_NEG / DEF_VS_NEG, 0 / 0, reset sync polarity (1 = active-low).

Ports:
- pclk, in, 1, pixel clock. This is the only clock.
- rst, in, 1, synchronous, active-high reset.
- enable, in, 1. Low: counters held at 0 and outputs inactive.
- pause, in, 1. High: counters freeze and de is forced 0.
- cfg_h_total, cfg_h_active, cfg_h_fp, cfg_h_sync, in, CNT_W each, staged horizontal timing.
- cfg_v_total, cfg_v_active, cfg_v_fp, cfg_v_sync, in, CNT_W each, staged vertical timing.
- cfg_hs_neg, cfg_vs_neg, in, 1 each, staged sync polarity.
- cfg_load, in, 1. Single-cycle strobe that captures all cfg_* inputs.
- cfg_pending, out, 1. A validated config is staged and not yet applied.
- cfg_err, out, 1. One-cycle pulse when a cfg_load is rejected.
- hsync, vsync, de, out, 1 each, timing outputs (polarity applied to the syncs).
- x, out, CNT_W, active pixel column (0 outside de).
- y, out, CNT_W, active line (0 outside the active lines).
- line_start, out, 1. Pulse when the output corresponds to hcnt = 0.
- frame_start, out, 1. Pulse when the output corresponds to hcnt = 0 and vcnt = 0.

## Operation
- Line layout: hcnt runs 0..h_total-1, blanking first.
  - h_blank = h_total - h_active.
  - hsync active for hcnt in [h_fp, h_fp+h_sync).
  - Pixel active for hcnt ≥ h_blank; x = hcnt - h_blank.
- Frame layout: vcnt runs 0..v_total-1 and increments when hcnt wraps.
  - v_blank = v_total - v_active.
  - vsync active for vcnt in [v_fp, v_fp+v_sync), aligned to hcnt = 0.
  - Active lines are vcnt ≥ v_blank; y = vcnt - v_blank.
- de = pixel active AND active line AND !pause.
- Syncs: hsync = active XOR hs_neg; vsync = active XOR vs_neg.
- Validation on cfg_load. The load is rejected (cfg_err = 1, staging unchanged) unless all of these hold:
  - h_total ≥ 2 and v_total ≥ 1.
  - 0 < h_active < h_total and 0 < v_active ≤ v_total.
  - h_fp + h_sync ≤ h_blank.
  - v_fp + v_sync ≤ v_blank.
  - All sums are computed at CNT_W+1 bits, so no overflow.
- Apply point: a frame boundary is the cycle where the counters go from (h_total-1, v_total-1) to (0,0) with pause low. At that point the staged config is copied to the active config and cfg_pending clears.
- While enable = 0, a staged config is applied on the next cycle.
- cfg_load on the same cycle as an apply: the previously staged config is applied; the new one becomes pending.
- cfg_load while a config is already pending: the staged config is overwritten by the newer valid load.
- pause: counters and the syncs hold their values; de is 0 and line_start/frame_start are 0; x and y hold.
- enable falling: on the next cycle the counters are 0 and the outputs are inactive. Enable rising: the frame starts at (0,0) and frame_start pulses.
- Reset:
  - Counters 0, active and staged config = DEF_*, cfg_pending = 0, cfg_err = 0.
  - de = 0, x = 0, y = 0, line_start = 0, frame_start = 0.
  - hsync = DEF_HS_NEG, vsync = DEF_VS_NEG.

## Timing
- All outputs are registered, with 1-cycle latency from counter state. hsync, vsync, de, x, y and the markers are mutually aligned.
- cfg_err rises the cycle after cfg_load. cfg_pending rises the cycle after a valid cfg_load.
- The first frame under a new config starts with frame_start on the output, 1 cycle after the boundary transition.
- Frame period = h_total × v_total cycles, excluding paused cycles.

## Structure
- Package video_timing_pkg holds:
  - typedef timing_cfg_t, a struct of the eight counts plus the two polarity bits;
  - DEF_CFG constant;
  - function cfg_valid(timing_cfg_t).
- Sub-module video_timing_cfg_shadow handles staging, validation, cfg_pending, cfg_err and the apply handshake. It has a frame_boundary input and outputs the active config.
- The top level holds the counters, the decode and the output registers.

## Test plan
All scenarios except the reset check use the small mode h_total = 10, h_active = 6, h_fp = 1, h_sync = 2, v_total = 5, v_active = 3, v_fp = 1, v_sync = 1.
- Reset release with defaults → 2200×1125-cycle frame; 1920×1080 de cycles per frame; hsync high on 44 consecutive cycles per line.
- Small mode, loaded while enable = 0:
  - hsync high at hcnt 1–2;
  - de at hcnt 4–9 on vcnt 2–4, giving 18 de cycles per 50-cycle frame;
  - x runs 0..5 and y runs 0..2.
- Valid cfg_load mid-frame:
  - cfg_pending = 1 until the boundary;
  - the old timing finishes the frame;
  - frame_start precedes the first frame in the new timing;
  - cfg_pending = 0 afterwards.
- Invalid cfg_load (h_fp = 3, h_sync = 2, h_blank = 4) → cfg_err pulses 1 cycle; timing unchanged; cfg_pending unchanged.
- pause held 7 cycles mid-line → de = 0 and counters frozen; the frame stretches by exactly 7 cycles.
- cfg_hs_neg = 1 and rst asserted mid-frame → on the next cycle all outputs take their reset values; the first post-reset hsync uses DEF polarity.
